// File: rtl/command_packer_pkg.sv
// ---------------------------------------------------------------------------
// command_packer_pkg
//   Items shared by the command packer files: the default FIFO word width,
//   the command codes understood by the downstream dispatcher, the packer
//   state encoding, and a helper that forms the {command, data} word.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package command_packer_pkg;

  localparam int FIFO_WIDTH = 16;

  // Dispatcher command codes. The packer itself forwards every code unchanged.
  localparam logic [7:0] CMD_DATA   = 8'h00;
  localparam logic [7:0] CMD_AUX_LO = 8'h01;
  localparam logic [7:0] CMD_AUX_HI = 8'h02;
  localparam logic [7:0] CMD_DELAY  = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // waiting for the command byte
    ST_HAVE_CMD = 2'd1,  // command latched, waiting for the data byte
    ST_WRITE    = 2'd2   // complete word waiting for FIFO space
  } state_e;

  function automatic logic [15:0] pack_word(input logic [7:0] cmd,
                                            input logic [7:0] data);
    return {cmd, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/command_packer_if.sv
// ---------------------------------------------------------------------------
// command_packer_if
//   Host byte handshake plus input-FIFO write port of the command packer.
//   Modports:
//     slave  : the packer (accepts host bytes, writes the FIFO)
//     master : the host bridge / FIFO side
//   Signals:
//     host_data[7:0], host_valid -> packer ; host_ready <- packer
//     in_fifo_in_full -> packer ; in_fifo_in_clock, in_fifo_in_shift,
//     in_fifo_in_data[WIDTH-1:0] <- packer
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface command_packer_if
  import command_packer_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) ();

  logic [7:0]       host_data;
  logic             host_valid;
  logic             host_ready;
  logic             in_fifo_in_clock;
  logic             in_fifo_in_full;
  logic             in_fifo_in_shift;
  logic [WIDTH-1:0] in_fifo_in_data;

  modport slave (
    input  host_data,
    input  host_valid,
    output host_ready,
    output in_fifo_in_clock,
    input  in_fifo_in_full,
    output in_fifo_in_shift,
    output in_fifo_in_data
  );

  modport master (
    output host_data,
    output host_valid,
    input  host_ready,
    input  in_fifo_in_clock,
    output in_fifo_in_full,
    input  in_fifo_in_shift,
    input  in_fifo_in_data
  );

endinterface

`default_nettype wire

// File: rtl/command_packer_idle_timeout.sv
// ---------------------------------------------------------------------------
// idle_timeout
//   Counts enabled cycles and raises a terminal-count pulse in the cycle in
//   which the count would reach LIMIT. The counter returns to zero on the
//   terminal count or on clear. LIMIT = 0 disables the timer.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en_i       : count this cycle
//     clr_i      : return count to zero (wins over en_i)
//     tc_o       : terminal count reached this cycle (combinational)
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idle_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int            CW     = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TC_VAL = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;
  localparam bit            ENABLE = (LIMIT != 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The count only ever holds 0..LIMIT-1: reaching LIMIT is signalled
  // combinationally from LIMIT-1 so the owner can react on the same edge.
  assign tc_o = ENABLE && en_i && (count_q == TC_VAL);

  always_comb begin
    count_d = count_q;
    if (clr_i || tc_o) begin
      count_d = '0;
    end else if (en_i && ENABLE) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/command_packer.sv
// ---------------------------------------------------------------------------
// command_packer
//   Collects a command byte followed by a data byte from the host bridge and
//   writes them as one {command, data} word into the input FIFO. A partial
//   word is dropped on flush or when the data byte does not arrive within
//   TIMEOUT_CYCLES idle cycles.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     flush_i        : drop any partial or pending word
//     bus (slave)    : host byte handshake and FIFO write port
//     timeout_err_o  : one-cycle pulse when a partial word times out
//     word_count_o   : words written since reset (wraps)
//     busy_o         : packer is not idle
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module command_packer
  import command_packer_pkg::*;
#(
  parameter int FIFO_WIDTH     = command_packer_pkg::FIFO_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  command_packer_if.slave       bus,
  output logic                  timeout_err_o,
  output logic [15:0]           word_count_o,
  output logic                  busy_o
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] word_count_q;

  logic        host_ready;
  logic        fifo_shift;
  logic        tmo_en;
  logic        tmo_clr;
  logic        tmo_tc;
  logic [15:0] word;

  // The idle counter only runs while a command is waiting and no byte is
  // offered. In HAVE_CMD an offered byte is always taken unless flush is
  // high, so host_valid alone stands in for acceptance when clearing.
  assign tmo_en  = (state_q == ST_HAVE_CMD) && !bus.host_valid;
  assign tmo_clr = (state_q != ST_HAVE_CMD) || bus.host_valid || flush_i;

  idle_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (tmo_en),
    .clr_i (tmo_clr),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    timeout_err_d = 1'b0;
    host_ready    = 1'b0;
    fifo_shift    = 1'b0;

    if (flush_i) begin
      // Flush blocks the handshake and the FIFO write for this cycle.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          host_ready = 1'b1;
          if (bus.host_valid) begin
            cmd_d   = bus.host_data;
            state_d = ST_HAVE_CMD;
          end
        end
        ST_HAVE_CMD: begin
          host_ready = 1'b1;
          // Acceptance takes priority over a timeout in the same cycle.
          if (bus.host_valid) begin
            data_d  = bus.host_data;
            state_d = ST_WRITE;
          end else if (tmo_tc) begin
            timeout_err_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (!bus.in_fifo_in_full) begin
            fifo_shift = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      data_q        <= '0;
      timeout_err_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      timeout_err_q <= timeout_err_d;
      if (fifo_shift) begin
        word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  // The word is built straight from the byte registers, so it only moves
  // when a byte is accepted and is steady for as long as WRITE is held.
  assign word = pack_word(cmd_q, data_q);

  generate
    if (FIFO_WIDTH > 16) begin : g_pad_word
      assign bus.in_fifo_in_data = {{(FIFO_WIDTH - 16){1'b0}}, word};
    end else begin : g_exact_word
      assign bus.in_fifo_in_data = word[FIFO_WIDTH-1:0];
    end
  endgenerate

  assign bus.in_fifo_in_clock = clk;
  assign bus.in_fifo_in_shift = fifo_shift;
  assign bus.host_ready       = host_ready;

  assign timeout_err_o = timeout_err_q;
  assign word_count_o  = word_count_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/command_packer.md
COMMAND_PACKER -- requirements
Module: command_packer

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, SHALL set the width of the command word written to the input FIFO.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the idle cycles allowed between command byte and data byte; 0 disables the timeout.
REQ-003 clock  input  1  single block clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 host_data  input  8  byte from the host bridge.
REQ-006 host_valid  input  1  host_data is valid this cycle.
REQ-007 host_ready  output  1  packer accepts host_data this cycle.
REQ-008 flush  input  1  synchronous request to drop any partial or pending word.
REQ-009 in_fifo_in_clock  output  1  FIFO write clock, driven directly from clock.
REQ-010 in_fifo_in_full  input  1  input FIFO cannot accept a word.
REQ-011 in_fifo_in_shift  output  1  one-cycle write strobe into the input FIFO.
REQ-012 in_fifo_in_data  output  FIFO_WIDTH  word as {command[15:8], data[7:0]}.
REQ-013 timeout_err  output  1  one-cycle pulse when a partial word is abandoned by timeout.
REQ-014 word_count  output  16  count of words written since reset.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE (await command byte), HAVE_CMD (await data byte), and WRITE (word pending to the FIFO).
REQ-017 host_ready SHALL be 1 in IDLE and HAVE_CMD and 0 in WRITE; a byte transfers only when host_valid and host_ready are both 1.
REQ-018 A byte accepted in IDLE SHALL be latched into the command register, and the FSM SHALL go to HAVE_CMD.
REQ-019 A byte accepted in HAVE_CMD SHALL be latched into the data register, and the FSM SHALL go to WRITE.
REQ-020 In WRITE with in_fifo_in_full=0, in_fifo_in_shift SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-021 Latency SHALL be as follows: data byte accepted at edge N gives shift high in the cycle after edge N when the FIFO is not full.
REQ-022 In WRITE with in_fifo_in_full=1, shift SHALL stay 0 and the FSM SHALL hold in WRITE with in_fifo_in_data stable, with no byte loss and no duplicate write.
REQ-023 in_fifo_in_data SHALL be stable whenever shift=1, and SHALL change only on byte acceptance.
REQ-024 Command bytes SHALL be passed through unchecked; all 256 codes are legal.
REQ-025 In HAVE_CMD, the timeout counter SHALL increment on each cycle with host_valid=0 and SHALL clear on acceptance or on leaving HAVE_CMD.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES (nonzero), the FSM SHALL discard the command, go to IDLE, and pulse timeout_err for one cycle.
REQ-027 If a byte is accepted in the same cycle the timeout is reached, acceptance SHALL win: no timeout occurs and the FSM goes to WRITE.
REQ-028 flush=1 SHALL force IDLE on the next edge from any state, with no shift that cycle and any byte offered that cycle ignored (host_ready=0 while flush=1).
REQ-029 word_count SHALL increment by 1 on every cycle with shift=1, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-030 reset=0 SHALL immediately force IDLE and set host_ready=1 (after release), in_fifo_in_shift=0, in_fifo_in_data=0, timeout_err=0, word_count=0, busy=0, and the timeout counter to 0.
REQ-031 Reset asserted mid-word SHALL discard the partial or pending word, and no shift SHALL be issued for it after release.

Structure
REQ-032 The shared package SHALL hold FIFO_WIDTH, the dispatch command codes (0x00 data, 0x01 aux low, 0x02 aux high, 0x03 delay), and the FSM state encoding.
REQ-033 The timeout counter SHALL be a single sub-module named idle_timeout (enable, clear, terminal-count pulse); everything else SHALL be inline.

Verification
REQ-034 Send bytes 0x00, 0xA5 with full=0 -> one shift with data 0x00A5 one cycle after the second byte, and word_count=1.
REQ-035 Hold full=1 and send 0x03, 0x10 -> host_ready=0 and data held at 0x0310 with no shift; release full after 20 cycles -> exactly one shift.
REQ-036 Set TIMEOUT_CYCLES=4, send 0x02, then idle -> timeout_err pulses after 4 idle cycles and the next two bytes 0x01, 0x00 produce word 0x0100.
REQ-037 Assert flush in HAVE_CMD and again in WRITE with full=1 -> no shift, IDLE next cycle, word_count unchanged.
REQ-038 Preload word_count near wrap via 65536 words (or a forced count) -> 0xFFFF then 0x0000; reset=0 mid-word -> no shift after release and all outputs at their reset values.
